// File: rtl/nec_ir_tx.sv
// NEC infrared transmitter: sends a full address/command frame or a repeat code
// as a baseband line (idle high, burst low) plus a carrier-modulated LED drive.
module nec_ir_tx #(
  parameter int T_560US     = 14000,
  parameter int T_1690US    = 42250,
  parameter int T_2250US    = 56250,
  parameter int T_4500US    = 112500,
  parameter int T_9MS       = 225000,
  parameter int T_GAP       = 1000000,
  parameter int CARRIER_DIV = 658
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       tx_start,
  input  logic       rep_start,
  input  logic [7:0] addr,
  input  logic [7:0] cmd,
  output logic       inf_out,
  output logic       ir_led,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LEAD      = 3'd1;
  localparam logic [2:0] S_SPACE     = 3'd2;
  localparam logic [2:0] S_BIT_MARK  = 3'd3;
  localparam logic [2:0] S_BIT_SPACE = 3'd4;
  localparam logic [2:0] S_STOP      = 3'd5;
  localparam logic [2:0] S_GAP       = 3'd6;

  // Timer reload values are duration-1 so a segment lasts exactly its duration.
  localparam logic [19:0] L_560  = 20'(T_560US - 1);
  localparam logic [19:0] L_1690 = 20'(T_1690US - 1);
  localparam logic [19:0] L_2250 = 20'(T_2250US - 1);
  localparam logic [19:0] L_4500 = 20'(T_4500US - 1);
  localparam logic [19:0] L_9MS  = 20'(T_9MS - 1);
  localparam logic [19:0] L_GAP  = 20'(T_GAP - 1);

  localparam logic [9:0] CAR_LAST = 10'(CARRIER_DIV - 1);
  localparam logic [9:0] CAR_HALF = 10'(CARRIER_DIV / 2);

  logic [2:0]  r_state;
  logic [19:0] r_timer;
  logic [4:0]  r_bit_idx;
  logic [31:0] r_shift;
  logic        r_rep;
  logic [9:0]  r_car_cnt;

  logic w_timer_zero;
  logic w_burst;

  assign w_timer_zero = (r_timer == 20'd0);
  assign w_burst      = (r_state == S_LEAD) || (r_state == S_BIT_MARK) || (r_state == S_STOP);

  assign inf_out = ~w_burst;
  assign ir_led  = w_burst && (r_car_cnt < CAR_HALF);
  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_GAP) && w_timer_zero;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_rep     <= 1'b0;
      r_car_cnt <= '0;
    end else begin
      if (r_car_cnt == CAR_LAST) r_car_cnt <= '0;
      else                       r_car_cnt <= r_car_cnt + 10'd1;

      if (!w_timer_zero) r_timer <= r_timer - 20'd1;

      // Entering a burst restarts the carrier so every burst begins with a high half-period.
      case (r_state)
        S_IDLE: begin
          if (tx_start) begin
            r_shift   <= {~cmd, cmd, ~addr, addr};
            r_rep     <= 1'b0;
            r_state   <= S_LEAD;
            r_timer   <= L_9MS;
            r_car_cnt <= '0;
          end else if (rep_start) begin
            r_rep     <= 1'b1;
            r_state   <= S_LEAD;
            r_timer   <= L_9MS;
            r_car_cnt <= '0;
          end
        end
        S_LEAD: begin
          if (w_timer_zero) begin
            r_state <= S_SPACE;
            r_timer <= r_rep ? L_2250 : L_4500;
          end
        end
        S_SPACE: begin
          if (w_timer_zero) begin
            r_state   <= r_rep ? S_STOP : S_BIT_MARK;
            r_bit_idx <= '0;
            r_timer   <= L_560;
            r_car_cnt <= '0;
          end
        end
        S_BIT_MARK: begin
          if (w_timer_zero) begin
            r_state <= S_BIT_SPACE;
            r_timer <= r_shift[r_bit_idx] ? L_1690 : L_560;
          end
        end
        S_BIT_SPACE: begin
          if (w_timer_zero) begin
            if (r_bit_idx == 5'd31) begin
              r_state <= S_STOP;
            end else begin
              r_state   <= S_BIT_MARK;
              r_bit_idx <= r_bit_idx + 5'd1;
            end
            r_timer   <= L_560;
            r_car_cnt <= '0;
          end
        end
        S_STOP: begin
          if (w_timer_zero) begin
            r_state <= S_GAP;
            r_timer <= L_GAP;
          end
        end
        S_GAP: begin
          if (w_timer_zero) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nec_ir_tx.sv
// Directed bench for nec_ir_tx with shortened segment durations so whole
// frames fit in a few thousand cycles; run lengths are measured on inf_out.
module tb_nec_ir_tx;

  localparam int T560  = 4;
  localparam int T1690 = 12;
  localparam int T2250 = 8;
  localparam int T4500 = 16;
  localparam int T9MS  = 32;
  localparam int TGAP  = 20;
  localparam int CDIV  = 10;
  localparam int LIMIT = 1000;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       tx_start = 1'b0;
  logic       rep_start = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] cmd = 8'h00;
  logic       inf_out, ir_led, busy, done;

  int         n_checks = 0;
  int         n_fail = 0;
  int         led_space_hits = 0;
  logic [63:0] led_trace;

  nec_ir_tx #(
    .T_560US(T560), .T_1690US(T1690), .T_2250US(T2250), .T_4500US(T4500),
    .T_9MS(T9MS), .T_GAP(TGAP), .CARRIER_DIV(CDIV)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_start(tx_start), .rep_start(rep_start),
    .addr(addr), .cmd(cmd), .inf_out(inf_out), .ir_led(ir_led), .busy(busy), .done(done)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Counts consecutive negedge samples at level lvl; ends on the first sample of the next level.
  task automatic measure(input logic lvl, output int n);
    n = 0;
    led_trace = '0;
    while (inf_out === lvl && n < LIMIT) begin
      if (n < 64) led_trace[n] = ir_led;
      if (lvl && ir_led) led_space_hits++;
      n++;
      @(negedge sys_clk);
    end
  endtask

  task automatic pulse(input logic t, input logic r, input logic [7:0] a, input logic [7:0] c);
    @(negedge sys_clk);
    tx_start = t; rep_start = r; addr = a; cmd = c;
    @(negedge sys_clk);
    tx_start = 1'b0; rep_start = 1'b0;
  endtask

  task automatic expect_frame(input logic [7:0] a, input logic [7:0] c, input logic rep);
    int n, dn;
    logic [31:0] data, exp_data;
    exp_data = {~c, c, ~a, a};
    data = '0;
    measure(1'b0, n); check("lead_len", n, T9MS);
    measure(1'b1, n); check("space_len", n, rep ? T2250 : T4500);
    if (!rep) begin
      for (int i = 0; i < 32; i++) begin
        measure(1'b0, n); check("mark_len", n, T560);
        measure(1'b1, n);
        data[i] = (n == T1690);
        check("bit_space_len", n, exp_data[i] ? T1690 : T560);
      end
      check("data_word", data, exp_data);
    end
    measure(1'b0, n); check("stop_len", n, T560);
    check("stop_carrier", led_trace[3:0], 4'hF);
    n = 0; dn = 0;
    while (busy && n < LIMIT) begin
      if (done) dn++;
      if (ir_led || !inf_out) led_space_hits++;
      n++;
      @(negedge sys_clk);
    end
    check("gap_len", n, TGAP);
    check("done_count", dn, 1);
  endtask

  initial begin
    int n, bad;
    logic [31:0] exp_led;

    // Reset state held, then 1000 idle cycles.
    repeat (3) @(negedge sys_clk);
    check("rst_outputs", {inf_out, ir_led, busy, done}, 4'b1000);
    sys_rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge sys_clk);
      if ({inf_out, ir_led, busy, done} !== 4'b1000) bad++;
    end
    check("idle_1000", bad, 0);

    // Full frame addr 0x00 cmd 0x45, with carrier pattern during LEAD.
    pulse(1'b1, 1'b0, 8'h00, 8'h45);
    check("busy_on_accept", busy, 1'b1);
    measure(1'b0, n); check("lead_len", n, T9MS);
    exp_led = '0;
    for (int i = 0; i < 32; i++) exp_led[i] = ((i % CDIV) < CDIV / 2);
    check("lead_carrier", led_trace[31:0], exp_led);
    measure(1'b1, n); check("space_len", n, T4500);
    begin
      logic [31:0] data, exp_data;
      exp_data = 32'hBA45FF00;
      data = '0;
      for (int i = 0; i < 32; i++) begin
        measure(1'b0, n); check("mark_len", n, T560);
        measure(1'b1, n);
        data[i] = (n == T1690);
      end
      check("data_0x45", data, exp_data);
    end
    measure(1'b0, n); check("stop_len", n, T560);
    bad = 0; n = 0;
    while (busy && n < LIMIT) begin
      if (done) bad++;
      n++;
      @(negedge sys_clk);
    end
    check("gap_len", n, TGAP);
    check("done_once", bad, 1);
    check("idle_after", {inf_out, busy, done}, 3'b100);

    // Repeat code.
    pulse(1'b0, 1'b1, 8'h00, 8'h00);
    expect_frame(8'h00, 8'h00, 1'b1);

    // Simultaneous request (tx wins), then ignored requests while busy.
    fork
      begin
        pulse(1'b1, 1'b1, 8'h5A, 8'hC3);
        expect_frame(8'h5A, 8'hC3, 1'b0);
      end
      begin
        repeat (60) @(negedge sys_clk);
        tx_start = 1'b1; addr = 8'hAA; cmd = 8'h11;
        @(negedge sys_clk);
        tx_start = 1'b0;
        repeat (150) @(negedge sys_clk);
        rep_start = 1'b1;
        @(negedge sys_clk);
        rep_start = 1'b0;
      end
    join
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge sys_clk);
      if (busy) bad++;
    end
    check("no_queued_req", bad, 0);
    check("led_in_spaces", led_space_hits, 0);

    // Reset during BIT_SPACE of bit 17.
    pulse(1'b1, 1'b0, 8'h81, 8'h7E);
    measure(1'b0, n);
    measure(1'b1, n);
    for (int i = 0; i < 17; i++) begin
      measure(1'b0, n);
      measure(1'b1, n);
    end
    measure(1'b0, n);
    check("at_bit17_space", {inf_out, busy}, 2'b11);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check("async_rst", {inf_out, ir_led, busy, done}, 4'b1000);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("post_rst_idle", {inf_out, busy}, 2'b10);
    pulse(1'b1, 1'b0, 8'h81, 8'h7E);
    expect_frame(8'h81, 8'h7E, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
